// File: rtl/cska_pkg.sv
// Shared types and helpers for the pipelined carry-skip adder.
// A stage register carries the partially built sum plus the operands still to be added.
package cska_pkg;

    localparam int BLK_W = 2;
    localparam int MAX_W = 64;

    function automatic int calc_stages(input int width, input int blk_per_stage);
        return width / (BLK_W * blk_per_stage);
    endfunction

    // Operand fields keep the whole operand; each stage only reads its own slice.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [MAX_W-1:0] sum_lo;
        logic [MAX_W-1:0] a_hi;
        logic [MAX_W-1:0] b_hi;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

endpackage

// File: rtl/cska_block.sv
// 2-bit ripple adder with a carry-skip bypass around it.
module cska_block
    import cska_pkg::*;
(
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] sum,
    output logic             cout
);

    logic [BLK_W-1:0] p;
    logic [BLK_W-1:0] g;
    logic             c1;
    logic             ripple;
    logic             sel;

    assign p      = a ^ b;
    assign g      = a & b;
    assign c1     = g[0] | (p[0] & cin);
    assign sum    = {p[1] ^ c1, p[0] ^ cin};
    assign ripple = g[1] | (p[1] & c1);

    selunit u_sel (
        .p   (p),
        .sel (sel)
    );

    // When both bits propagate the ripple result equals cin, so the mux is exact.
    assign cout = sel ? cin : ripple;

endmodule

// File: rtl/selunit.sv
// Skip-select for one carry-skip block: bypass when every bit propagates.
module selunit
    import cska_pkg::*;
(
    input  logic [BLK_W-1:0] p,
    output logic             sel
);

    assign sel = &p;

endmodule

// File: rtl/cska_pipe_adder.sv
// Pipelined carry-skip adder: stage k adds bits [k*S+S-1:k*S] of the operands held in
// its register and hands the carry and growing sum to the next register.
module cska_pipe_adder
    import cska_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int BLK_PER_STAGE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S      = BLK_W * BLK_PER_STAGE;
    localparam int STAGES = calc_stages(WIDTH, BLK_PER_STAGE);
    localparam int NBLK   = WIDTH / BLK_W;

    if ((WIDTH % S) != 0) begin : g_bad_width
        $error("cska_pipe_adder: WIDTH must be a multiple of 2*BLK_PER_STAGE");
    end
    if (WIDTH > MAX_W) begin : g_too_wide
        $error("cska_pipe_adder: WIDTH exceeds MAX_W");
    end

    // st[0] holds the accepted operands; st[k+1] holds the result of adding slice k.
    stage_t             st  [0:STAGES];
    stage_t             nxt [0:STAGES-1];
    stage_t             head;
    logic [WIDTH-1:0]   blk_sum;
    logic [STAGES-1:0]  stage_cout;
    logic               adv;

    // Stream handshake: a beat moves on a rising edge when valid and ready are both high;
    // the whole pipe advances together whenever the output register is empty or drained.
    assign out_valid = st[STAGES].valid;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_comb begin
        head = '0;
        if (in_valid) begin
            head.valid = 1'b1;
            head.carry = cin;
            head.a_hi  = MAX_W'(a);
            head.b_hi  = MAX_W'(b);
            head.a_msb = a[WIDTH-1];
            head.b_msb = b[WIDTH-1];
        end
    end

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int J = i / BLK_PER_STAGE;
        logic             c_in;
        logic             c_out;
        logic [BLK_W-1:0] s;

        if ((i % BLK_PER_STAGE) == 0) begin : g_head
            assign c_in = st[J].carry;
        end else begin : g_chain
            assign c_in = g_blk[i-1].c_out;
        end

        cska_block u_blk (
            .a    (st[J].a_hi[BLK_W*i +: BLK_W]),
            .b    (st[J].b_hi[BLK_W*i +: BLK_W]),
            .cin  (c_in),
            .sum  (s),
            .cout (c_out)
        );

        assign blk_sum[BLK_W*i +: BLK_W] = s;

        if ((i % BLK_PER_STAGE) == (BLK_PER_STAGE - 1)) begin : g_tail
            assign stage_cout[J] = c_out;
        end
    end

    always_comb begin
        for (int j = 0; j < STAGES; j++) begin
            nxt[j]                = st[j];
            nxt[j].carry          = stage_cout[j];
            nxt[j].sum_lo[j*S +: S] = blk_sum[j*S +: S];
        end
    end

    // Bubbles load as all-zero and stay zero through the adder stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                st[k] <= '0;
            end
        end else if (adv) begin
            st[0] <= head;
            for (int j = 0; j < STAGES; j++) begin
                st[j+1] <= nxt[j];
            end
        end
    end

    assign sum  = st[STAGES].sum_lo[WIDTH-1:0];
    assign cout = st[STAGES].carry;
    assign ovf  = (st[STAGES].a_msb == st[STAGES].b_msb) &&
                  (st[STAGES].sum_lo[WIDTH-1] != st[STAGES].a_msb);

endmodule
